// File: rtl/stopwatch_mux_display_pkg.sv
// Shared constants for the stopwatch: segment patterns, display FSM states, digit moduli.
package stopwatch_mux_display_pkg;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low, bit 0 = CA ... bit 6 = CG.
  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // Tens-of-seconds and tens-of-minutes positions roll over at 6.
  function automatic logic [3:0] digit_mod(input int unsigned idx);
    return (idx == 1 || idx == 3) ? 4'd6 : 4'd10;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern.
module seg7_decoder
  import stopwatch_mux_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_encode(bcd_i);

endmodule

// File: rtl/stopwatch_mux_display.sv
// Up/down stopwatch with a multiplexed, blanked seven-segment display.
module stopwatch_mux_display
  import stopwatch_mux_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned REFRESH_DIV  = 50_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_reset,
  input  logic                  i_w_start_stop,
  input  logic                  i_w_clear,
  input  logic                  i_w_mode,
  output logic [NUM_DIGITS-1:0] o_r_an,
  output logic [6:0]            o_r_seg,
  output logic                  o_r_dp,
  output logic                  o_r_running
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW = $clog2(NUM_DIGITS);

  logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
  logic [PW-1:0]              presc_q, presc_d;
  logic                       running_q, running_d;
  logic                       tick;
  logic                       carry;
  logic                       count_zero;

  logic [0:0]                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SW-1:0]              slot_q, slot_d;
  logic [6:0]                 dec_seg;

  assign tick       = running_q && (presc_q == PW'(TICK_DIV - 1));
  assign count_zero = (digits_q == '0);

  always_comb begin
    digits_d  = digits_q;
    presc_d   = presc_q;
    running_d = running_q;
    carry     = 1'b1;
    if (i_w_start_stop) begin
      running_d = (i_w_mode && count_zero) ? 1'b0 : ~running_q;
    end
    if (i_w_clear) begin
      digits_d = '0;
      presc_d  = '0;
    end else begin
      if (running_q) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
        // carry doubles as borrow when counting down
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (carry) begin
            if (!i_w_mode) begin
              if (digits_q[i] == 4'(digit_mod(i) - 4'd1)) begin
                digits_d[i] = 4'd0;
              end else begin
                digits_d[i] = digits_q[i] + 4'd1;
                carry       = 1'b0;
              end
            end else begin
              if (digits_q[i] == 4'd0) begin
                digits_d[i] = 4'(digit_mod(i) - 4'd1);
              end else begin
                digits_d[i] = digits_q[i] - 4'd1;
                carry       = 1'b0;
              end
            end
          end
        end
        if (i_w_mode && (digits_d == '0)) begin
          running_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      digits_q  <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
    end else begin
      digits_q  <= digits_d;
      presc_q   <= presc_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    slot_d  = slot_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CW'(REFRESH_DIV - BLANK_CYCLES - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          slot_d  = (slot_q == SW'(NUM_DIGITS - 1)) ? '0 : slot_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .bcd_i (digits_q[slot_q]),
    .seg_o (dec_seg)
  );

  // Outputs are registered from the current state, so they trail the FSM by one clock.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      slot_q  <= '0;
      o_r_an  <= '1;
      o_r_seg <= SEG_OFF;
      o_r_dp  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      if (state_q == ST_DRIVE) begin
        o_r_an  <= ~(NUM_DIGITS'(1) << slot_q);
        o_r_seg <= dec_seg;
        o_r_dp  <= (slot_q != SW'(2));
      end else begin
        o_r_an  <= '1;
        o_r_seg <= SEG_OFF;
        o_r_dp  <= 1'b1;
      end
    end
  end

  assign o_r_running = running_q;

endmodule

// File: tb/tb_stopwatch_mux_display.sv
// Randomised and directed checks of the stopwatch against an arithmetic reference model.
module tb_stopwatch_mux_display;

  localparam int unsigned ND = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ss = 1'b0;
  logic          clr = 1'b0;
  logic          mode = 1'b0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic          running;

  int n_vec  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  stopwatch_mux_display #(
    .NUM_DIGITS   (ND),
    .TICK_DIV     (TD),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .i_w_clk        (clk),
    .i_w_reset      (rst),
    .i_w_start_stop (ss),
    .i_w_clear      (clr),
    .i_w_mode       (mode),
    .o_r_an         (an),
    .o_r_seg        (seg),
    .o_r_dp         (dp),
    .o_r_running    (running)
  );

  initial forever #5 clk = ~clk;

  function automatic int unsigned modv(input int unsigned i);
    return (i == 1 || i == 3) ? 10 - 4 : 10;
  endfunction

  function automatic int unsigned total();
    int unsigned t = 1;
    for (int unsigned i = 0; i < ND; i++) t = t * modv(i);
    return t;
  endfunction

  function automatic int unsigned mdig(input int unsigned v, input int unsigned i);
    int unsigned d = v;
    for (int unsigned j = 0; j < i; j++) d = d / modv(j);
    return d % modv(i);
  endfunction

  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count held as a single integer, display position as an edge counter.
  int unsigned m_v = 0, m_p = 0, m_e = 0;
  bit          m_r = 1'b0;
  logic [ND-1:0] e_an = '1;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_run = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_v = 0; m_p = 0; m_r = 0; m_e = 0;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_run = 1'b0;
    end else begin
      int unsigned phase, slot;
      bit tk, nr;
      phase = m_e % RD;
      slot  = (m_e / RD) % ND;
      if (phase >= BC) begin
        e_an  = ~(ND'(1) << slot);
        e_seg = seg_of(mdig(m_v, slot));
        e_dp  = (slot != 2);
      end else begin
        e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
      end
      m_e++;
      tk = m_r && (m_p == TD - 1);
      nr = m_r;
      if (ss) nr = (mode && m_v == 0) ? 1'b0 : !m_r;
      if (clr) begin
        m_v = 0; m_p = 0;
      end else begin
        if (m_r) m_p = tk ? 0 : m_p + 1;
        if (tk) begin
          if (!mode) m_v = (m_v + 1) % total();
          else begin
            m_v = (m_v + total() - 1) % total();
            if (m_v == 0) nr = 1'b0;
          end
        end
      end
      m_r   = nr;
      e_run = nr;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("running", 32'(running), 32'(e_run));
    end
  end

  task automatic cyc(input logic s, input logic c, input logic m);
    @(negedge clk);
    ss = s; clr = c; mode = m;
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic m);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, m);
  endtask

  task automatic wait_slot(input int unsigned s, input logic [6:0] exp_seg, input string name);
    bit found = 1'b0;
    @(negedge clk);
    ss = 1'b0; clr = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (an == ~(ND'(1) << s)) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      n_vec++; n_fail++;
      $display("FAIL %s: slot %0d never driven, an=%b", name, s, an);
    end else begin
      chk(name, 32'(seg), 32'(exp_seg));
    end
  endtask

  task automatic check_refresh_seq(input string name);
    logic [ND-1:0] exp_seq [18];
    exp_seq = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF,
                4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF};
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk(name, 32'(an), 32'(exp_seq[k]));
      if (k == 2) chk({name, "_seg0"}, 32'(seg), 32'h40);
    end
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_run", 32'(running), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check_refresh_seq("refresh");

    // Count up 40 ticks, then 20 more.
    cyc(1'b1, 1'b0, 1'b0); idle(159, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    wait_slot(0, 7'h40, "up40_d0");
    wait_slot(1, 7'h19, "up40_d1");
    wait_slot(2, 7'h40, "up40_d2");
    cyc(1'b1, 1'b0, 1'b0); idle(79, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    wait_slot(1, 7'h40, "up60_d1");
    wait_slot(2, 7'h79, "up60_d2");

    // Reach 59:59, then wrap.
    cyc(1'b1, 1'b0, 1'b0); idle(4 * 3539 - 1, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    wait_slot(0, 7'h10, "max_d0");
    wait_slot(1, 7'h12, "max_d1");
    wait_slot(3, 7'h12, "max_d3");
    cyc(1'b1, 1'b0, 1'b0); idle(3, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("wrap_run", 32'(running), 32'h1);
    cyc(1'b1, 1'b0, 1'b0);
    wait_slot(0, 7'h40, "wrap_d0");
    wait_slot(3, 7'h40, "wrap_d3");

    // Up to 00:02, then count down to zero and auto-stop.
    cyc(1'b1, 1'b1, 1'b0); idle(8, 1'b0); idle(8, 1'b1);
    @(negedge clk);
    chk("down_stop", 32'(running), 32'h0);
    cyc(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("down_nostart", 32'(running), 32'h0);
    wait_slot(0, 7'h40, "down_d0");

    // Clear colliding with a tick at 00:07.
    cyc(1'b1, 1'b1, 1'b0); idle(31, 1'b0); cyc(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("clr_run", 32'(running), 32'h1);
    cyc(1'b1, 1'b0, 1'b0);
    wait_slot(0, 7'h40, "clr_d0");

    // Asynchronous reset in the middle of slot 2's drive phase.
    cyc(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1011) found = 1'b1;
    end
    if (!found) begin
      n_vec++; n_fail++;
      $display("FAIL arst_wait: slot 2 never driven, an=%b", an);
    end
    chk("arst_pre_dp", 32'(dp), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp), 32'h1);
    chk("arst_run", 32'(running), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_refresh_seq("refresh2");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic s, c, m;
      s = ($urandom_range(0, 31) == 0);
      c = ($urandom_range(0, 99) == 0);
      m = mode;
      if ($urandom_range(0, 63) == 0) m = ~mode;
      cyc(s, c, m);
    end
    @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
